// File: rtl/screen_end_animated.sv
// screen_end_animated: game-over compositor revealing text lines, counting the score up, optional last-line blink (SCREEN_END_BLINK_EN)
module screen_end_animated #(
  parameter int NUM_LINES = 3,
  parameter int REVEAL_FRAMES = 30,
  parameter int COUNT_STEP = 7,
  parameter int BLINK_FRAMES = 16,
  parameter logic [7:0] BG_COLOR = 8'hFF
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic                   startOfFrame,
  input  logic                   active,
  input  logic [15:0]            score,
  input  logic [NUM_LINES-1:0]   lineDraw,
  input  logic [8*NUM_LINES-1:0] lineRGB,
  input  logic                   numberDraw,
  input  logic [7:0]             numberRGB,
  output logic [7:0]             RGB_screen_end,
  output logic [15:0]            displayScore,
  output logic                   animDone
);
  localparam int MAX_FRAMES = REVEAL_FRAMES > BLINK_FRAMES ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int FW = $clog2(MAX_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, REVEAL, COUNT, HOLD} state_t;
  state_t state, state_n;
  logic [2:0] revealed, revealed_n;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [15:0] target, target_n, score_n;
  logic active_d;
  logic last_gate;
  logic [7:0] pix;
  logic unused_pixel;
  assign unused_pixel = ^{pixelX, pixelY};
  assign animDone = state == HOLD;
`ifdef SCREEN_END_BLINK_EN
  logic blink_phase, blink_n;
  assign last_gate = state != HOLD || blink_phase;
`else
  assign last_gate = 1'b1;
`endif
  // state and animation registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      revealed <= '0;
      frame_cnt <= '0;
      target <= '0;
      displayScore <= '0;
      active_d <= 1'b0;
      RGB_screen_end <= BG_COLOR;
`ifdef SCREEN_END_BLINK_EN
      blink_phase <= 1'b1;
`endif
    end else begin
      state <= state_n;
      revealed <= revealed_n;
      frame_cnt <= frame_n;
      target <= target_n;
      displayScore <= score_n;
      active_d <= active;
      RGB_screen_end <= pix;
`ifdef SCREEN_END_BLINK_EN
      blink_phase <= blink_n;
`endif
    end
  end
  // next state; a falling active wins over a coincident frame pulse
  always_comb begin
    state_n = state;
    revealed_n = revealed;
    frame_n = frame_cnt;
    target_n = target;
    score_n = displayScore;
`ifdef SCREEN_END_BLINK_EN
    blink_n = blink_phase;
`endif
    if (state != IDLE && !active) begin
      state_n = IDLE;
      score_n = '0;
      revealed_n = '0;
      frame_n = '0;
    end else if (state == IDLE) begin
      if (active && !active_d) begin
        state_n = REVEAL;
        target_n = score;
        revealed_n = '0;
        frame_n = '0;
        score_n = '0;
      end
    end else if (startOfFrame) begin
      if (state == REVEAL) begin
        if (frame_cnt == FW'(REVEAL_FRAMES - 1)) begin
          frame_n = '0;
          revealed_n = revealed + 3'd1;
          state_n = revealed + 3'd1 == 3'(NUM_LINES) ? COUNT : REVEAL;
        end else
          frame_n = frame_cnt + FW'(1);
      end else if (state == COUNT) begin
        if (target - displayScore <= 16'(COUNT_STEP)) begin
          score_n = target;
          state_n = HOLD;
          frame_n = '0;
`ifdef SCREEN_END_BLINK_EN
          blink_n = 1'b1;
`endif
        end else
          score_n = displayScore + 16'(COUNT_STEP);
      end
`ifdef SCREEN_END_BLINK_EN
      else if (state == HOLD) begin
        frame_n = frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + FW'(1);
        blink_n = frame_cnt == FW'(BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
      end
`endif
    end
  end
  // composite: line 0 highest priority, then number, then background
  always_comb begin
    pix = (state == COUNT || state == HOLD) && numberDraw ? numberRGB : BG_COLOR;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (3'(i) < revealed && lineDraw[i] && (i != NUM_LINES - 1 || last_gate))
        pix = lineRGB[8*i +: 8];
    if (state == IDLE) pix = BG_COLOR;
  end
endmodule

// File: tb/tb_screen_end_animated.sv
// tb_screen_end_animated: directed self-checking bench for screen_end_animated
module tb_screen_end_animated;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic startOfFrame = 1'b0, active = 1'b0;
  logic [15:0] score = '0;
  logic [2:0] lineDraw = '0;
  logic [23:0] lineRGB = {8'h33, 8'h22, 8'h11};
  logic numberDraw = 1'b0;
  logic [7:0] numberRGB = 8'h44;
  logic [7:0] rgb;
  logic [15:0] disp;
  logic done;
  int tests = 0, fails = 0;

  screen_end_animated #(
    .NUM_LINES(3), .REVEAL_FRAMES(4), .COUNT_STEP(7), .BLINK_FRAMES(2), .BG_COLOR(8'hFF)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .active(active), .score(score),
    .lineDraw(lineDraw), .lineRGB(lineRGB), .numberDraw(numberDraw), .numberRGB(numberRGB),
    .RGB_screen_end(rgb), .displayScore(disp), .animDone(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic rise();
    active = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fall();
    active = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    check("rst_rgb", 16'(rgb), 16'hFF);
    check("rst_disp", disp, 16'd0);
    check("rst_done", 16'(done), 16'd0);
    // async reset mid-animation with inputs active
    lineDraw = 3'b111; numberDraw = 1'b1; score = 16'd20;
    rise();
    frames(4);
    check("pre_rst_rgb", 16'(rgb), 16'h11);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_rgb", 16'(rgb), 16'hFF);
    check("async_rst_disp", disp, 16'd0);
    check("async_rst_done", 16'(done), 16'd0);
    active = 1'b0;
    @(posedge clk); #1 resetN = 1'b1;
    @(posedge clk); #1;
    // run A: reveal, count, blink
    lineDraw = 3'b100; score = 16'd20;
    rise();
    for (int k = 1; k <= 11; k++) begin
      frame();
      check($sformatf("reveal_rgb_p%0d", k), 16'(rgb), 16'hFF);
      if (k == 5) score = 16'd999;
    end
    frame();
    check("reveal_rgb_p12", 16'(rgb), 16'h33);
    check("reveal_disp_p12", disp, 16'd0);
    lineDraw = 3'b000;
    #2 check("latency_hold", 16'(rgb), 16'h33);
    @(posedge clk); #1;
    check("latency_num", 16'(rgb), 16'h44);
    frame();
    check("count_p13", disp, 16'd7);
    check("count_done_p13", 16'(done), 16'd0);
    frame();
    check("count_p14", disp, 16'd14);
    check("count_done_p14", 16'(done), 16'd0);
    frame();
    check("count_p15", disp, 16'd20);
    check("count_done_p15", 16'(done), 16'd1);
    check("count_rgb_p15", 16'(rgb), 16'h44);
    lineDraw = 3'b100;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
`ifdef SCREEN_END_BLINK_EN
      check($sformatf("blink_%0d", k), 16'(rgb), (k == 2 || k == 3) ? 16'hFF : 16'h33);
`else
      check($sformatf("steady_%0d", k), 16'(rgb), 16'h33);
`endif
      frame();
    end
    check("hold_disp", disp, 16'd20);
    check("hold_done", 16'(done), 16'd1);
    fall();
    check("idle_done", 16'(done), 16'd0);
    check("idle_disp", disp, 16'd0);
    check("idle_rgb", 16'(rgb), 16'hFF);
    // run B: abort during COUNT coincident with a frame pulse
    lineDraw = 3'b000; score = 16'd20;
    rise();
    frames(13);
    check("abort_pre_disp", disp, 16'd7);
    active = 1'b0; startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
    check("abort_disp", disp, 16'd0);
    check("abort_done", 16'(done), 16'd0);
    @(posedge clk); #1;
    check("abort_rgb", 16'(rgb), 16'hFF);
    // run C: restart with new score, revealed starts over
    lineDraw = 3'b001; score = 16'd5;
    rise();
    frames(3);
    check("restart_rgb_p3", 16'(rgb), 16'hFF);
    frame();
    check("restart_rgb_p4", 16'(rgb), 16'h11);
    lineDraw = 3'b000;
    frames(8);
    check("restart_rgb_p12", 16'(rgb), 16'h44);
    frame();
    check("restart_disp", disp, 16'd5);
    check("restart_done", 16'(done), 16'd1);
    fall();
    // run D: zero score gives one COUNT pulse
    score = 16'd0;
    rise();
    frames(12);
    check("zero_done_p12", 16'(done), 16'd0);
    frame();
    check("zero_done_p13", 16'(done), 16'd1);
    check("zero_disp_p13", disp, 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
